// File: rtl/serdesphy_ana_cdr_loop_if.sv
// Sampler/control bundle between the RX front end and the CDR loop.
// The master side drives samples and loop controls; the slave side is the CDR.
interface serdesphy_ana_cdr_loop_if #(
    parameter int PI_W   = 32'sd6,
    parameter int FREQ_W = 32'sd10
);
    logic                     enable;
    logic                     freeze;
    logic                     data_sample;
    logic                     edge_sample;
    logic [1:0]               kp_sel;
    logic [1:0]               ki_sel;
    logic [PI_W-1:0]          pi_code;
    logic signed [FREQ_W-1:0] freq_offset;
    logic                     rx_data;
    logic                     rx_data_valid;
    logic                     cdr_lock;

    modport master (
        output enable, freeze, data_sample, edge_sample, kp_sel, ki_sel,
        input  pi_code, freq_offset, rx_data, rx_data_valid, cdr_lock
    );

    modport slave (
        input  enable, freeze, data_sample, edge_sample, kp_sel, ki_sel,
        output pi_code, freq_offset, rx_data, rx_data_valid, cdr_lock
    );
endinterface

// File: rtl/serdesphy_ana_cdr_loop.sv
// Digital CDR loop: Alexander bang-bang phase detector, vote-decimating
// PI loop filter with saturating integrator, and ACQUIRE/TRACK/LOCKED FSM.
// The phase accumulator wraps modulo 2^PACC_W; pi_code is its integer part.
module serdesphy_ana_cdr_loop #(
    parameter int PI_W       = 32'sd6,
    parameter int FRAC_W     = 32'sd4,
    parameter int FREQ_W     = 32'sd10,
    parameter int DECIM      = 32'sd8,
    parameter int ACQ_WIN    = 32'sd16,
    parameter int LOCK_THR   = 32'sd1,
    parameter int LOCK_CNT   = 32'sd32,
    parameter int UNLOCK_CNT = 32'sd4
) (
    input  logic                    clk_240m,
    input  logic                    rst,
    serdesphy_ana_cdr_loop_if.slave cdr
);
    localparam int PACC_W  = PI_W + FRAC_W;
    localparam int WIN_W   = $clog2(DECIM);
    localparam int SUM_W   = $clog2(DECIM) + 32'sd2;
    localparam int CNT_MAX = (ACQ_WIN > LOCK_CNT) ?
                             ((ACQ_WIN > UNLOCK_CNT) ? ACQ_WIN : UNLOCK_CNT) :
                             ((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT);
    localparam int CNT_W   = $clog2(CNT_MAX + 32'sd1);
    localparam logic signed [31:0] INTEG_MAX = (32'sd1 <<< (FREQ_W - 32'sd1)) - 32'sd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Clamp a wide integrator candidate to the symmetric range +/-INTEG_MAX.
    function automatic logic signed [FREQ_W-1:0] sat_integ(input logic signed [31:0] x);
        logic signed [31:0] y;
        if (x > INTEG_MAX) begin
            y = INTEG_MAX;
        end else if (x < -INTEG_MAX) begin
            y = -INTEG_MAX;
        end else begin
            y = x;
        end
        return FREQ_W'(y);
    endfunction

    state_t                   state_r, state_next_s;
    logic                     d_cur_r, d_prev_r, e_r;
    logic signed [1:0]        pd_vote_s, vote_r;
    logic [WIN_W-1:0]         win_cnt_r;
    logic signed [SUM_W-1:0]  sum_r, sum_next_s;
    logic [SUM_W-1:0]         sum_mag_s;
    logic [CNT_W-1:0]         cnt_r, cnt_next_s;
    logic [PACC_W-1:0]        pacc_r, pacc_next_s;
    logic signed [FREQ_W-1:0] integ_r, integ_next_s;
    logic                     count_s, close_s, quiet_s, sat_s;
    logic signed [31:0]       v_s, integ_ext_s, prop_s;
    int                       prop_sh_s;
    logic                     rx_data_valid_r, cdr_lock_r;

    assign count_s = cdr.enable & ~cdr.freeze & (state_r != ST_IDLE);
    assign close_s = count_s & (win_cnt_r == WIN_W'(DECIM - 32'sd1));

    // Stage 1: retime data, previous data and edge samples.
    always_ff @(posedge clk_240m) begin
        if (rst) begin
            d_cur_r  <= 1'b0;
            d_prev_r <= 1'b0;
            e_r      <= 1'b0;
        end else begin
            d_cur_r  <= cdr.data_sample;
            d_prev_r <= d_cur_r;
            e_r      <= cdr.edge_sample;
        end
    end

    // Alexander PD: edge matching the old bit means the clock samples early.
    always_comb begin
        pd_vote_s = 2'sd0;
        if ((d_prev_r != d_cur_r) && (e_r == d_prev_r)) begin
            pd_vote_s = 2'sd1;
        end else if ((d_prev_r != d_cur_r) && (e_r == d_cur_r)) begin
            pd_vote_s = -2'sd1;
        end else begin
            pd_vote_s = 2'sd0;
        end
    end

    // Stage 2: register the PD vote.
    always_ff @(posedge clk_240m) begin
        if (rst) begin
            vote_r <= 2'sd0;
        end else begin
            vote_r <= pd_vote_s;
        end
    end

    // Window sum, its sign and magnitude, and the loop-filter candidates.
    always_comb begin
        sum_next_s   = sum_r + $signed({{(SUM_W - 32'sd2){vote_r[1]}}, vote_r});
        sum_mag_s    = sum_next_s[SUM_W-1] ? SUM_W'(-sum_next_s) : SUM_W'(sum_next_s);
        quiet_s      = (sum_mag_s <= SUM_W'(LOCK_THR));
        sat_s        = (sum_mag_s == SUM_W'(DECIM));
        v_s          = 32'sd0;
        if (sum_next_s[SUM_W-1]) begin
            v_s = -32'sd1;
        end else if (sum_next_s != {SUM_W{1'b0}}) begin
            v_s = 32'sd1;
        end else begin
            v_s = 32'sd0;
        end
        integ_ext_s  = $signed({{(32'sd32 - FREQ_W){integ_r[FREQ_W-1]}}, integ_r});
        integ_next_s = sat_integ(integ_ext_s + (v_s <<< cdr.ki_sel));
        // Acquisition uses a 4x larger proportional step than tracking.
        prop_sh_s    = (state_r == ST_ACQUIRE) ? (FRAC_W + 32'sd1 + int'(cdr.kp_sel))
                                               : (FRAC_W - 32'sd1 + int'(cdr.kp_sel));
        prop_s       = v_s <<< prop_sh_s;
        pacc_next_s  = PACC_W'($signed({{(32'sd32 - PACC_W){1'b0}}, pacc_r})
                               + prop_s + (integ_ext_s >>> FRAC_W));
    end

    // Window counter and vote accumulator; cleared on disable or window close.
    always_ff @(posedge clk_240m) begin
        if (rst) begin
            win_cnt_r <= {WIN_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
        end else if (!cdr.enable || close_s) begin
            win_cnt_r <= {WIN_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
        end else if (count_s) begin
            win_cnt_r <= win_cnt_r + WIN_W'(32'd1);
            sum_r     <= sum_next_s;
        end else begin
            win_cnt_r <= win_cnt_r;
            sum_r     <= sum_r;
        end
    end

    // Lock FSM next state; cnt_r counts windows/quiet/saturated per state.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (!cdr.enable) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
        end else if (cdr.freeze || !(close_s || (state_r == ST_IDLE))) begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_ACQUIRE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
                ST_ACQUIRE: begin
                    if (cnt_r == CNT_W'(ACQ_WIN - 32'sd1)) begin
                        state_next_s = ST_TRACK;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(32'd1);
                    end
                end
                ST_TRACK: begin
                    if (!quiet_s) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_W'(LOCK_CNT - 32'sd1)) begin
                        state_next_s = ST_LOCKED;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(32'd1);
                    end
                end
                ST_LOCKED: begin
                    if (!sat_s) begin
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_W'(UNLOCK_CNT - 32'sd1)) begin
                        state_next_s = ST_TRACK;
                        cnt_next_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_next_s   = cnt_r + CNT_W'(32'd1);
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state, shared counter and registered status outputs.
    always_ff @(posedge clk_240m) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            rx_data_valid_r <= 1'b0;
            cdr_lock_r      <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            cnt_r           <= cnt_next_s;
            rx_data_valid_r <= (state_next_s != ST_IDLE);
            cdr_lock_r      <= (state_next_s == ST_LOCKED);
        end
    end

    // Loop filter update, applied only on a counted window close.
    always_ff @(posedge clk_240m) begin
        if (rst) begin
            pacc_r  <= {PACC_W{1'b0}};
            integ_r <= {FREQ_W{1'b0}};
        end else if (close_s) begin
            pacc_r  <= pacc_next_s;
            integ_r <= integ_next_s;
        end else begin
            pacc_r  <= pacc_r;
            integ_r <= integ_r;
        end
    end

    assign cdr.pi_code       = pacc_r[PACC_W-1:FRAC_W];
    assign cdr.freq_offset   = integ_r;
    assign cdr.rx_data       = d_cur_r;
    assign cdr.rx_data_valid = rx_data_valid_r;
    assign cdr.cdr_lock      = cdr_lock_r;
endmodule

// File: tb/tb_serdesphy_ana_cdr_loop.sv
// Directed bench for the CDR loop: reset, acquisition steps, wrap and
// integrator saturation, lock/unlock, freeze and enable handling.
module tb_serdesphy_ana_cdr_loop;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   ec = 0;          // edges since reset release
    int   mode = 0;        // 0 constant zero, 1 early pattern, 2 late pattern
    logic prev_data = 1'b0;

    serdesphy_ana_cdr_loop_if #(.PI_W(6), .FREQ_W(10)) cdr_bus ();

    serdesphy_ana_cdr_loop dut (
        .clk_240m (clk),
        .rst      (rst),
        .cdr      (cdr_bus)
    );

    always #5 clk = ~clk;

    // Drive one UI according to mode, then advance one clock edge.
    task automatic step();
        logic d;
        if (mode == 0) begin
            cdr_bus.data_sample = 1'b0;
            cdr_bus.edge_sample = 1'b0;
            prev_data = 1'b0;
        end else begin
            d = ~prev_data;
            cdr_bus.data_sample = d;
            cdr_bus.edge_sample = (mode == 1) ? prev_data : d;
            prev_data = d;
        end
        @(posedge clk); #1;
        ec++;
    endtask

    task automatic run_to(input int target);
        while (ec < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cdr_bus.enable = 1'b1;
        cdr_bus.freeze = 1'b0;
        cdr_bus.data_sample = 1'b0;
        cdr_bus.edge_sample = 1'b0;
        cdr_bus.kp_sel = 2'd0;
        cdr_bus.ki_sel = 2'd0;
        mode = 0;
        prev_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (cdr_bus.pi_code !== 6'd0) begin n_err++; $display("FAIL rst_pi: got %0d want 0", cdr_bus.pi_code); end
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd0) begin n_err++; $display("FAIL rst_freq: got %0d want 0", cdr_bus.freq_offset); end
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b0) begin n_err++; $display("FAIL rst_lock: got %b want 0", cdr_bus.cdr_lock); end
        n_vec++;
        if (cdr_bus.rx_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", cdr_bus.rx_data_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        ec = 0;
        n_vec++;
        if (cdr_bus.rx_data_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid: got %b want 1", cdr_bus.rx_data_valid); end
    endtask

    task automatic test_reset();
        do_reset();
        cdr_bus.data_sample = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (cdr_bus.rx_data !== 1'b1) begin n_err++; $display("FAIL rx_data_1: got %b want 1", cdr_bus.rx_data); end
        cdr_bus.data_sample = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (cdr_bus.rx_data !== 1'b0) begin n_err++; $display("FAIL rx_data_0: got %b want 0", cdr_bus.rx_data); end
    endtask

    // Sustained early votes in ACQUIRE: +2 codes and +1 integrator per window.
    task automatic test_acquire();
        do_reset();
        mode = 1;
        for (int k = 1; k <= 4; k++) begin
            run_to(8 * k - 1);
            n_vec++;
            if (cdr_bus.pi_code !== 6'(2 * (k - 1))) begin
                n_err++; $display("FAIL acq_hold w%0d: got %0d want %0d", k, cdr_bus.pi_code, 2 * (k - 1));
            end
            step();
            n_vec++;
            if (cdr_bus.pi_code !== 6'(2 * k)) begin
                n_err++; $display("FAIL acq_pi w%0d: got %0d want %0d", k, cdr_bus.pi_code, 2 * k);
            end
            n_vec++;
            if (cdr_bus.freq_offset !== 10'(k)) begin
                n_err++; $display("FAIL acq_freq w%0d: got %0d want %0d", k, cdr_bus.freq_offset, k);
            end
        end
    endtask

    // Step pi_code to 62 with shrinking kp, wrap through 0, then saturate integ.
    task automatic test_wrap_saturate();
        int exp_pi [8] = '{16, 32, 48, 56, 60, 62, 0, 2};
        do_reset();
        cdr_bus.kp_sel = 2'd3;
        mode = 1;
        for (int k = 1; k <= 8; k++) begin
            run_to(8 * k);
            n_vec++;
            if (cdr_bus.pi_code !== 6'(exp_pi[k-1])) begin
                n_err++; $display("FAIL wrap_pi w%0d: got %0d want %0d", k, cdr_bus.pi_code, exp_pi[k-1]);
            end
            n_vec++;
            if (cdr_bus.freq_offset !== 10'(k)) begin
                n_err++; $display("FAIL wrap_freq w%0d: got %0d want %0d", k, cdr_bus.freq_offset, k);
            end
            if (k == 3) cdr_bus.kp_sel = 2'd2;
            if (k == 4) cdr_bus.kp_sel = 2'd1;
            if (k == 5) cdr_bus.kp_sel = 2'd0;
        end
        cdr_bus.ki_sel = 2'd3;
        run_to(560);
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd504) begin n_err++; $display("FAIL sat_504: got %0d want 504", cdr_bus.freq_offset); end
        run_to(568);
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd511) begin n_err++; $display("FAIL sat_511a: got %0d want 511", cdr_bus.freq_offset); end
        run_to(576);
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd511) begin n_err++; $display("FAIL sat_511b: got %0d want 511", cdr_bus.freq_offset); end
    endtask

    // Quiet input: 16 ACQUIRE windows plus 32 quiet TRACK windows to lock.
    task automatic test_lock();
        do_reset();
        mode = 0;
        run_to(383);
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", cdr_bus.cdr_lock); end
        step();
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b1) begin n_err++; $display("FAIL lock_set: got %b want 1", cdr_bus.cdr_lock); end
        n_vec++;
        if (cdr_bus.pi_code !== 6'd0) begin n_err++; $display("FAIL lock_pi: got %0d want 0", cdr_bus.pi_code); end
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd0) begin n_err++; $display("FAIL lock_freq: got %0d want 0", cdr_bus.freq_offset); end
    endtask

    // From LOCKED, sustained late votes: 4 saturated windows drop lock.
    task automatic test_unlock();
        mode = 2;
        run_to(392);
        n_vec++;
        if (cdr_bus.pi_code !== 6'd63) begin n_err++; $display("FAIL unl_pi49: got %0d want 63", cdr_bus.pi_code); end
        run_to(408);
        n_vec++;
        if (cdr_bus.pi_code !== 6'd62) begin n_err++; $display("FAIL unl_pi51: got %0d want 62", cdr_bus.pi_code); end
        run_to(416);
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b1) begin n_err++; $display("FAIL unl_still: got %b want 1", cdr_bus.cdr_lock); end
        n_vec++;
        if (cdr_bus.pi_code !== 6'd61) begin n_err++; $display("FAIL unl_pi52: got %0d want 61", cdr_bus.pi_code); end
        run_to(424);
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b0) begin n_err++; $display("FAIL unl_drop: got %b want 0", cdr_bus.cdr_lock); end
        n_vec++;
        if (cdr_bus.freq_offset !== 10'h3FB) begin n_err++; $display("FAIL unl_freq: got %0d want -5", cdr_bus.freq_offset); end
        n_vec++;
        if (cdr_bus.rx_data_valid !== 1'b1) begin n_err++; $display("FAIL unl_valid: got %b want 1", cdr_bus.rx_data_valid); end
    endtask

    // Freeze across two window boundaries, then drop enable mid-window.
    task automatic test_freeze_enable();
        do_reset();
        mode = 0;
        run_to(384);
        cdr_bus.freeze = 1'b1;
        mode = 1;
        run_to(400);
        n_vec++;
        if (cdr_bus.pi_code !== 6'd0) begin n_err++; $display("FAIL frz_pi: got %0d want 0", cdr_bus.pi_code); end
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd0) begin n_err++; $display("FAIL frz_freq: got %0d want 0", cdr_bus.freq_offset); end
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b1) begin n_err++; $display("FAIL frz_lock: got %b want 1", cdr_bus.cdr_lock); end
        cdr_bus.freeze = 1'b0;
        run_to(408);
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd1) begin n_err++; $display("FAIL thaw_freq: got %0d want 1", cdr_bus.freq_offset); end
        run_to(416);
        n_vec++;
        if (cdr_bus.pi_code !== 6'd1) begin n_err++; $display("FAIL thaw_pi: got %0d want 1", cdr_bus.pi_code); end
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b1) begin n_err++; $display("FAIL thaw_lock: got %b want 1", cdr_bus.cdr_lock); end
        run_to(419);
        cdr_bus.enable = 1'b0;
        step();
        n_vec++;
        if (cdr_bus.cdr_lock !== 1'b0) begin n_err++; $display("FAIL dis_lock: got %b want 0", cdr_bus.cdr_lock); end
        n_vec++;
        if (cdr_bus.rx_data_valid !== 1'b0) begin n_err++; $display("FAIL dis_valid: got %b want 0", cdr_bus.rx_data_valid); end
        run_to(432);
        n_vec++;
        if (cdr_bus.pi_code !== 6'd1) begin n_err++; $display("FAIL dis_pi: got %0d want 1", cdr_bus.pi_code); end
        n_vec++;
        if (cdr_bus.freq_offset !== 10'd2) begin n_err++; $display("FAIL dis_freq: got %0d want 2", cdr_bus.freq_offset); end
    endtask

    initial begin
        cdr_bus.enable = 1'b1;
        cdr_bus.freeze = 1'b0;
        cdr_bus.data_sample = 1'b0;
        cdr_bus.edge_sample = 1'b0;
        cdr_bus.kp_sel = 2'd0;
        cdr_bus.ki_sel = 2'd0;
        test_reset();
        test_acquire();
        test_wrap_saturate();
        test_lock();
        test_unlock();
        test_freeze_enable();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
